// File: rtl/apb_slave_mem_pkg.sv
// apb_pkg: shared bus widths and FSM state type for the APB slave memory
package apb_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
endpackage

// File: rtl/apb_slave_mem_if.sv
// apb_slave_mem_if: APB bus bundle (select/enable/write/addr/wdata in; rdata/ready/slverr/proto_err out)
interface apb_slave_mem_if;
  import apb_pkg::*;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;
  logic              proto_err;
  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr, proto_err);
  modport slave (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr, proto_err);
endinterface

// File: rtl/apb_slave_mem_regfile.sv
// apb_slave_regfile: byte storage with one sync write port, one comb read port, sync clear
//   clk clock, clr_i clears every location, we_i/addr_i/wdata_i write port, rdata_o read data
module apb_slave_regfile import apb_pkg::*; #(
  parameter int DEPTH = 32
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (clr_i) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (we_i) mem_q[addr_i[IW-1:0]] <= wdata_i;
  assign rdata_o = {1'b0, addr_i} < (ADDR_W+1)'(DEPTH) ? mem_q[addr_i[IW-1:0]] : '0;
endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave with DEPTH-byte memory, WAIT_CYCLES wait states and sticky protocol-error flag
//   pclk clock, preset sync active-high reset, bus APB slave modport
module apb_slave_mem import apb_pkg::*; #(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 1
) (
  input logic            pclk,
  input logic            preset,
  apb_slave_mem_if.slave bus
);
  localparam int CW = $clog2(WAIT_CYCLES + 2);
  if (DEPTH > 2**ADDR_W || DEPTH < 1) begin : g_bad_depth
    $error("apb_slave_mem: DEPTH must be within 1..256");
  end
  apb_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata;
  logic              write_q, perr_q;
  logic              pready, in_range, abort, viol, we;
  always_comb begin
    in_range = {1'b0, addr_q} < (ADDR_W+1)'(DEPTH);
    pready   = state_q == ACCESS && cnt_q == CW'(WAIT_CYCLES);
    // master dropped psel/penable before the slave finished: abandon the transfer
    abort    = state_q == ACCESS && !pready && (!bus.psel || !bus.penable);
    viol     = ((state_q == IDLE || state_q == SETUP) && bus.penable) || abort;
    we       = pready && write_q && in_range;
    state_d  = state_q == IDLE  ? (bus.psel && !bus.penable ? SETUP : IDLE) :
               state_q == SETUP ? ACCESS :
               abort            ? IDLE :
               !pready          ? ACCESS :
               bus.psel && !bus.penable ? SETUP : IDLE;
    cnt_d    = state_q == SETUP ? '0 : state_q == ACCESS && !pready ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge pclk)
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_q | viol;
      if (state_q == SETUP) begin
        addr_q  <= bus.paddr;
        write_q <= bus.pwrite;
        wdata_q <= bus.pwdata;
      end
    end
  apb_slave_regfile #(.DEPTH(DEPTH)) u_regfile (
    .clk     (pclk),
    .clr_i   (preset),
    .we_i    (we),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );
  assign bus.pready    = pready;
  assign bus.pslverr   = pready && !in_range;
  assign bus.prdata    = pready && !write_q && in_range ? rdata : '0;
  assign bus.proto_err = perr_q;
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed bench for apb_slave_mem with WAIT_CYCLES=1 and WAIT_CYCLES=0 instances
module tb_apb_slave_mem;
  logic clk = 1'b0;
  logic preset = 1'b1;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  apb_slave_mem_if b1();
  apb_slave_mem_if b0();
  apb_slave_mem #(.DEPTH(32), .WAIT_CYCLES(1)) u1 (.pclk(clk), .preset(preset), .bus(b1));
  apb_slave_mem #(.DEPTH(32), .WAIT_CYCLES(0)) u0 (.pclk(clk), .preset(preset), .bus(b0));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int u, input logic s, e, w, input logic [7:0] a, d);
    if (u == 0) begin
      b0.psel = s; b0.penable = e; b0.pwrite = w; b0.paddr = a; b0.pwdata = d;
    end else begin
      b1.psel = s; b1.penable = e; b1.pwrite = w; b1.paddr = a; b1.pwdata = d;
    end
  endtask

  function automatic logic rdy(input int u);
    return u == 0 ? b0.pready : b1.pready;
  endfunction

  task automatic idle(input int u);
    drive(u, 0, 0, 0, 8'h00, 8'h00);
    step();
  endtask

  // request cycle, SETUP cycle, then ACCESS cycles until pready; returns in the pready cycle
  task automatic xfer(input int u, input logic wr, input logic [7:0] a, d, acc_a,
                      output logic [7:0] rd, output logic er, output int waits, output int at);
    drive(u, 1, 0, wr, a, d);
    step();
    drive(u, 1, 0, wr, a, d);
    step();
    waits = 0;
    drive(u, 1, 1, wr, acc_a, d);
    #1;
    while (!rdy(u) && waits < 16) begin
      waits++;
      step();
      drive(u, 1, 1, wr, acc_a, d);
      #1;
    end
    rd = u == 0 ? b0.prdata : b1.prdata;
    er = u == 0 ? b0.pslverr : b1.pslverr;
    at = cyc;
    tests++;
    if (!rdy(u)) begin fails++; $display("FAIL xfer_timeout dut%0d addr %h: pready never rose", u, a); end
  endtask

  task automatic test_reset();
    preset = 1'b1;
    drive(0, 0, 0, 0, 8'h00, 8'h00);
    drive(1, 0, 0, 0, 8'h00, 8'h00);
    step();
    step();
    tests++; if (b1.pready !== 1'b0) begin fails++; $display("FAIL rst_pready got %b want 0", b1.pready); end
    tests++; if (b1.pslverr !== 1'b0) begin fails++; $display("FAIL rst_pslverr got %b want 0", b1.pslverr); end
    tests++; if (b1.prdata !== 8'h00) begin fails++; $display("FAIL rst_prdata got %h want 00", b1.prdata); end
    tests++; if (b1.proto_err !== 1'b0) begin fails++; $display("FAIL rst_proto_err got %b want 0", b1.proto_err); end
    preset = 1'b0;
    step();
    tests++; if (b1.pready !== 1'b0) begin fails++; $display("FAIL post_rst_pready got %b want 0", b1.pready); end
    tests++; if (b0.pready !== 1'b0) begin fails++; $display("FAIL post_rst_pready0 got %b want 0", b0.pready); end
    tests++; if (b1.prdata !== 8'h00) begin fails++; $display("FAIL post_rst_prdata got %h want 00", b1.prdata); end
  endtask

  task automatic test_write();
    logic [7:0] rd; logic er; int w, t;
    xfer(1, 1, 8'd3, 8'h21, 8'd3, rd, er, w, t);
    tests++; if (w !== 1) begin fails++; $display("FAIL wr_waits got %0d want 1", w); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL wr_slverr got %b want 0", er); end
    idle(1);
    xfer(1, 0, 8'd3, 8'h00, 8'd3, rd, er, w, t);
    tests++; if (rd !== 8'h21) begin fails++; $display("FAIL rd3 got %h want 21", rd); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL rd3_slverr got %b want 0", er); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; logic er; int w, t0, t1;
    xfer(1, 1, 8'd14, 8'h50, 8'd14, rd, er, w, t0);
    xfer(1, 0, 8'd14, 8'h00, 8'd14, rd, er, w, t1);
    tests++; if (rd !== 8'h50) begin fails++; $display("FAIL b2b_rd14 got %h want 50", rd); end
    tests++; if (t1 - t0 !== 3) begin fails++; $display("FAIL b2b_gap got %0d want 3", t1 - t0); end
    idle(1);
  endtask

  task automatic test_error();
    logic [7:0] rd; logic er; int w, t;
    xfer(1, 1, 8'd40, 8'h55, 8'd40, rd, er, w, t);
    tests++; if (er !== 1'b1) begin fails++; $display("FAIL err_wr40 slverr got %b want 1", er); end
    idle(1);
    xfer(1, 0, 8'd40, 8'h00, 8'd40, rd, er, w, t);
    tests++; if (rd !== 8'h00) begin fails++; $display("FAIL err_rd40 got %h want 00", rd); end
    tests++; if (er !== 1'b1) begin fails++; $display("FAIL err_rd40 slverr got %b want 1", er); end
    idle(1);
    xfer(1, 0, 8'd8, 8'h00, 8'd8, rd, er, w, t);
    tests++; if (rd !== 8'h00) begin fails++; $display("FAIL err_alias8 got %h want 00", rd); end
    idle(1);
    xfer(1, 0, 8'd3, 8'h00, 8'd3, rd, er, w, t);
    tests++; if (rd !== 8'h21) begin fails++; $display("FAIL err_keep3 got %h want 21", rd); end
    idle(1);
  endtask

  task automatic test_addr_change();
    logic [7:0] rd; logic er; int w, t;
    xfer(1, 0, 8'd3, 8'h00, 8'd14, rd, er, w, t);
    tests++; if (rd !== 8'h21) begin fails++; $display("FAIL latch_addr got %h want 21", rd); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd; logic er; int w, t;
    drive(1, 1, 0, 1, 8'd5, 8'hAA);
    step();
    drive(1, 1, 0, 1, 8'd5, 8'hAA);
    step();
    drive(1, 1, 1, 1, 8'd5, 8'hAA);
    #1;
    tests++; if (b1.pready !== 1'b0) begin fails++; $display("FAIL mid_acc1 pready got %b want 0", b1.pready); end
    step();
    #1;
    tests++; if (b1.pready !== 1'b1) begin fails++; $display("FAIL mid_acc2 pready got %b want 1", b1.pready); end
    preset = 1'b1;
    step();
    preset = 1'b0;
    drive(1, 0, 0, 0, 8'h00, 8'h00);
    step();
    tests++; if (b1.pready !== 1'b0) begin fails++; $display("FAIL mid_after pready got %b want 0", b1.pready); end
    xfer(1, 0, 8'd5, 8'h00, 8'd5, rd, er, w, t);
    tests++; if (rd !== 8'h00) begin fails++; $display("FAIL mid_rd5 got %h want 00", rd); end
    idle(1);
    xfer(1, 0, 8'd3, 8'h00, 8'd3, rd, er, w, t);
    tests++; if (rd !== 8'h00) begin fails++; $display("FAIL mid_clr3 got %h want 00", rd); end
    idle(1);
  endtask

  task automatic test_proto_idle();
    logic [7:0] rd; logic er; int w, t;
    drive(1, 0, 1, 0, 8'h00, 8'h00);
    step();
    drive(1, 0, 0, 0, 8'h00, 8'h00);
    tests++; if (b1.proto_err !== 1'b1) begin fails++; $display("FAIL pe_idle got %b want 1", b1.proto_err); end
    tests++; if (b0.proto_err !== 1'b0) begin fails++; $display("FAIL pe_other got %b want 0", b0.proto_err); end
    step();
    step();
    xfer(1, 0, 8'd3, 8'h00, 8'd3, rd, er, w, t);
    idle(1);
    tests++; if (b1.proto_err !== 1'b1) begin fails++; $display("FAIL pe_sticky got %b want 1", b1.proto_err); end
    preset = 1'b1;
    step();
    preset = 1'b0;
    tests++; if (b1.proto_err !== 1'b0) begin fails++; $display("FAIL pe_clear got %b want 0", b1.proto_err); end
    step();
  endtask

  task automatic test_abort();
    logic [7:0] rd; logic er; int w, t;
    drive(1, 1, 0, 1, 8'd7, 8'h77);
    step();
    drive(1, 1, 0, 1, 8'd7, 8'h77);
    step();
    drive(1, 0, 1, 1, 8'd7, 8'h77);
    step();
    drive(1, 0, 0, 0, 8'h00, 8'h00);
    tests++; if (b1.proto_err !== 1'b1) begin fails++; $display("FAIL abort_pe got %b want 1", b1.proto_err); end
    step();
    xfer(1, 0, 8'd7, 8'h00, 8'd7, rd, er, w, t);
    tests++; if (rd !== 8'h00) begin fails++; $display("FAIL abort_rd7 got %h want 00", rd); end
    idle(1);
  endtask

  task automatic test_proto_setup();
    logic [7:0] rd; logic er; int w, t;
    preset = 1'b1;
    step();
    preset = 1'b0;
    drive(1, 1, 0, 1, 8'd2, 8'h66);
    step();
    drive(1, 1, 1, 1, 8'd2, 8'h66);
    step();
    tests++; if (b1.proto_err !== 1'b1) begin fails++; $display("FAIL pe_setup got %b want 1", b1.proto_err); end
    step();
    #1;
    tests++; if (b1.pready !== 1'b1) begin fails++; $display("FAIL pe_setup_done pready got %b want 1", b1.pready); end
    idle(1);
    xfer(1, 0, 8'd2, 8'h00, 8'd2, rd, er, w, t);
    tests++; if (rd !== 8'h66) begin fails++; $display("FAIL pe_setup_rd2 got %h want 66", rd); end
    idle(1);
  endtask

  task automatic test_zero_wait();
    logic [7:0] rd; logic er; int w, t;
    xfer(0, 1, 8'd9, 8'h3C, 8'd9, rd, er, w, t);
    tests++; if (w !== 0) begin fails++; $display("FAIL zw_wr_waits got %0d want 0", w); end
    idle(0);
    xfer(0, 0, 8'd9, 8'h00, 8'd9, rd, er, w, t);
    tests++; if (w !== 0) begin fails++; $display("FAIL zw_rd_waits got %0d want 0", w); end
    tests++; if (rd !== 8'h3C) begin fails++; $display("FAIL zw_rd9 got %h want 3c", rd); end
    idle(0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_error();
    test_addr_change();
    test_reset_mid();
    test_proto_idle();
    test_abort();
    test_proto_setup();
    test_zero_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
